conv_window_linebuf: RTL and testbench

//  Streaming 3x3 window generator that feeds the kernel-application stage.

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_line_ram.sv | 26 ++
 rtl/conv_window_linebuf.sv | 159 +++++++++++++++
 tb/tb_conv_window_linebuf.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 streaming window generator.
package conv_pkg;

    localparam int DEF_PIX_W = 8;                // default signed pixel width
    localparam int K         = 3;                // kernel edge length
    localparam int K_CTR     = 1;                // centre offset inside the kernel
    localparam int WIN_W     = K * K * DEF_PIX_W; // flattened window width at default PIX_W

    // Frame sequencing: FILL primes the two line buffers, RUN emits windows,
    // DONE is the one-cycle end-of-frame marker.
    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/conv_line_ram.sv
// One image line of pixels: asynchronous read, synchronous write, same address.
module conv_line_ram #(
    parameter int DEPTH = 247,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read returns the old word; a write in the same cycle lands at the clock edge.
    assign rd_data_o = mem_q[addr_i];

    // Storage update on write.
    // NOTE: line storage has no reset; every word is written during FILL before it is read for a window.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/conv_window_linebuf.sv
// Streaming 3x3 window generator with two line buffers and a 1-deep output register.
// Optional feature macro: WIN_COORD_EN adds out_row/out_col carrying the window centre.
module conv_window_linebuf
    import conv_pkg::*;
#(
    parameter int ROWS  = 242,
    parameter int COLS  = 247,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIX_W-1:0]         in_pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [K*K*PIX_W-1:0]     out_win,
`ifdef WIN_COORD_EN
    output logic [15:0]              out_row,
    output logic [15:0]              out_col,
`endif
    output logic                     frame_done
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    state_e               state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CW-1:0]        col_q, col_d;
    logic                 out_valid_q, out_valid_d;
    logic [K*K*PIX_W-1:0] out_win_q, out_win_d;
    logic [PIX_W-1:0]     win_q [K][K];
    logic [PIX_W-1:0]     win_d [K][K];
    logic [PIX_W-1:0]     new_col [K];
    logic [PIX_W-1:0]     lb0_rd, lb1_rd;
    logic                 accept, emit, last_col, last_row;

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign last_col   = (col_q == CW'(COLS - 1));
    assign last_row   = (row_q == RW'(ROWS - 1));
    // Columns 0 and 1 of each row still hold the previous row's tail, so they never emit.
    assign emit       = accept && (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1));
    assign out_valid  = out_valid_q;
    assign out_win    = out_win_q;
    assign frame_done = (state_q == ST_DONE);

    // lb0 holds row-1; on accept its old word moves into lb1 (row-2).
    conv_line_ram #(.DEPTH(COLS), .WIDTH(PIX_W)) u_lb0 (
        .clk       (clk),
        .wr_en_i   (accept),
        .addr_i    (col_q),
        .wr_data_i (in_pixel),
        .rd_data_o (lb0_rd)
    );

    conv_line_ram #(.DEPTH(COLS), .WIDTH(PIX_W)) u_lb1 (
        .clk       (clk),
        .wr_en_i   (accept),
        .addr_i    (col_q),
        .wr_data_i (lb0_rd),
        .rd_data_o (lb1_rd)
    );

    // Next window: shift left one column and append {row-2, row-1, current} at the right.
    always_comb begin
        new_col[0] = lb1_rd;
        new_col[1] = lb0_rd;
        new_col[2] = in_pixel;
        for (int ki = 0; ki < K; ki++) begin
            for (int kj = 0; kj < K - 1; kj++) begin
                win_d[ki][kj] = win_q[ki][kj + 1];
            end
            win_d[ki][K - 1] = new_col[ki];
        end
    end

    // Counters, FSM and output register next-state.
    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        out_win_d   = out_win_q;

        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        if (emit) begin
            out_valid_d = 1'b1;
            for (int ki = 0; ki < K; ki++) begin
                for (int kj = 0; kj < K; kj++) begin
                    out_win_d[(ki * K + kj) * PIX_W +: PIX_W] = win_d[ki][kj];
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_FILL: if (accept && last_col && row_q == RW'(K - 2)) state_d = ST_RUN;
            ST_RUN:  if (accept && last_col && last_row)            state_d = ST_DONE;
            ST_DONE: state_d = ST_FILL;
            default: state_d = ST_FILL;
        endcase
    end

    // Window shift register; stale contents are masked by the emit gate, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            win_q <= win_d;
        end
    end

    // Control and output registers with synchronous reset.
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_win_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_win_q   <= out_win_d;
        end
    end

`ifdef WIN_COORD_EN
    logic [15:0] out_row_q, out_col_q;

    assign out_row = out_row_q;
    assign out_col = out_col_q;

    // Centre coordinates travel with the window and follow the same load/hold/reset rules.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_row_q <= '0;
            out_col_q <= '0;
        end else if (emit) begin
            out_row_q <= 16'(row_q) - 16'(K - 1 - K_CTR);
            out_col_q <= 16'(col_q) - 16'(K - 1 - K_CTR);
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_linebuf.sv
// Scoreboard bench: a 4x5 instance for directed scenarios and a 242x247 instance for a random stream.
`timescale 1ns/1ps
module tb_conv_window_linebuf;

    localparam int PW = 8;
    localparam int WW = 9 * PW;
    localparam int R0 = 4,   C0 = 5;
    localparam int R1 = 242, C1 = 247;

    typedef struct packed {
        logic [WW-1:0] win;
        logic [15:0]   row;
        logic [15:0]   col;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst       [2];
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [PW-1:0] in_pixel  [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [WW-1:0] out_win   [2];
    logic          frame_done[2];
`ifdef WIN_COORD_EN
    logic [15:0]   out_row   [2];
    logic [15:0]   out_col   [2];
`endif

    conv_window_linebuf #(.ROWS(R0), .COLS(C0), .PIX_W(PW)) u_small (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_pixel(in_pixel[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_win(out_win[0]),
`ifdef WIN_COORD_EN
        .out_row(out_row[0]), .out_col(out_col[0]),
`endif
        .frame_done(frame_done[0])
    );

    conv_window_linebuf #(.ROWS(R1), .COLS(C1), .PIX_W(PW)) u_big (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_pixel(in_pixel[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_win(out_win[1]),
`ifdef WIN_COORD_EN
        .out_row(out_row[1]), .out_col(out_col[1]),
`endif
        .frame_done(frame_done[1])
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model state per instance.
    logic [PW-1:0] img0 [2][R0][C0];   // small instance: image per frame parity
    logic [PW-1:0] img1 [R1][C1];      // big instance: one random frame
    int            mr[2], mc[2], mf[2], acc_cnt[2], win_cnt[2], done_cnt[2];
    int            stall_at[2], stall_left[2];
    bit            prev_push[2], prev_hold[2], done_due[2];
    logic [WW-1:0] prev_win[2];
    exp_t          q0[$], q1[$];
    logic [WW-1:0] got0[$];

    function automatic logic [PW-1:0] pix(input int d, input int f, input int r, input int c);
        if (d == 0) return img0[f % 2][r][c];
        return img1[r][c];
    endfunction

    function automatic int rows_of(input int d);
        return (d == 0) ? R0 : R1;
    endfunction

    function automatic int cols_of(input int d);
        return (d == 0) ? C0 : C1;
    endfunction

    task automatic reset_model(input int d);
        mr[d] = 0; mc[d] = 0; acc_cnt[d] = 0; win_cnt[d] = 0; done_cnt[d] = 0;
        stall_at[d] = -1; stall_left[d] = 0;
        prev_push[d] = 1'b0; prev_hold[d] = 1'b0; done_due[d] = 1'b0;
        if (d == 0) begin q0.delete(); got0.delete(); end
        else        q1.delete();
    endtask

    task automatic set_ramp(input int f, input int off);
        for (int r = 0; r < R0; r++)
            for (int c = 0; c < C0; c++)
                img0[f][r][c] = PW'(r * 5 + c + off);
    endtask

    // One clock of one instance: drive at the falling edge, then observe what the rising edge will do.
    task automatic step(input int d, input bit iv, input bit ordy);
        exp_t          e;
        bit            o;
        logic [WW-1:0] w;
        o = ordy;
        @(negedge clk);
        if (stall_left[d] > 0 && out_valid[d] === 1'b1 && win_cnt[d] == stall_at[d]) begin
            o = 1'b0;
            stall_left[d]--;
        end
        in_valid[d]  = iv;
        in_pixel[d]  = pix(d, mf[d], mr[d], mc[d]);
        out_ready[d] = o;
        #1;
        if (prev_push[d]) begin
            compared++;
            if (out_valid[d] !== 1'b1) begin
                mismatched++;
                $display("FAIL latency d%0d: out_valid=%b expected 1", d, out_valid[d]);
            end
        end
        if (prev_hold[d]) begin
            compared++;
            if (out_valid[d] !== 1'b1 || out_win[d] !== prev_win[d]) begin
                mismatched++;
                $display("FAIL hold d%0d: out_valid=%b win=%h expected 1 win=%h",
                         d, out_valid[d], out_win[d], prev_win[d]);
            end
        end
        compared++;
        if (frame_done[d] !== done_due[d]) begin
            mismatched++;
            $display("FAIL frame_done d%0d: got %b expected %b", d, frame_done[d], done_due[d]);
        end
        if (frame_done[d] === 1'b1) done_cnt[d]++;
        compared++;
        if (in_ready[d] !== (!out_valid[d] || o)) begin
            mismatched++;
            $display("FAIL in_ready d%0d: got %b expected %b", d, in_ready[d], !out_valid[d] || o);
        end
        if (out_valid[d] === 1'b1 && o) begin
            compared++;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                mismatched++;
                $display("FAIL window d%0d: got unexpected window %h expected none", d, out_win[d]);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                if (out_win[d] !== e.win) begin
                    mismatched++;
                    $display("FAIL window d%0d #%0d: got %h expected %h", d, win_cnt[d], out_win[d], e.win);
                end
`ifdef WIN_COORD_EN
                compared++;
                if (out_row[d] !== e.row || out_col[d] !== e.col) begin
                    mismatched++;
                    $display("FAIL coord d%0d: got (%0d,%0d) expected (%0d,%0d)",
                             d, out_row[d], out_col[d], e.row, e.col);
                end
`endif
            end
            if (d == 0) got0.push_back(out_win[d]);
            win_cnt[d]++;
        end
        prev_hold[d] = (out_valid[d] === 1'b1) && !o;
        prev_win[d]  = out_win[d];
        prev_push[d] = 1'b0;
        done_due[d]  = 1'b0;
        if (iv && in_ready[d] === 1'b1) begin
            if (mr[d] >= 2 && mc[d] >= 2) begin
                for (int ki = 0; ki < 3; ki++)
                    for (int kj = 0; kj < 3; kj++)
                        w[(ki * 3 + kj) * PW +: PW] = pix(d, mf[d], mr[d] - 2 + ki, mc[d] - 2 + kj);
                e.win = w;
                e.row = 16'(mr[d] - 1);
                e.col = 16'(mc[d] - 1);
                if (d == 0) q0.push_back(e); else q1.push_back(e);
                prev_push[d] = 1'b1;
            end
            acc_cnt[d]++;
            if (mc[d] == cols_of(d) - 1) begin
                mc[d] = 0;
                if (mr[d] == rows_of(d) - 1) begin
                    mr[d] = 0; mf[d]++; done_due[d] = 1'b1;
                end else begin
                    mr[d]++;
                end
            end else begin
                mc[d]++;
            end
        end
    endtask

    task automatic drain(input int d);
        for (int n = 0; n < 6; n++) step(d, 1'b0, 1'b1);
        compared++;
        if ((d == 0 && q0.size() != 0) || (d == 1 && q1.size() != 0)) begin
            mismatched++;
            $display("FAIL drain d%0d: got %0d windows outstanding expected 0", d, (d == 0) ? q0.size() : q1.size());
        end
    endtask

    task automatic run_small(input int npix);
        int start = acc_cnt[0];
        for (int n = 0; n < 400 && acc_cnt[0] - start < npix; n++) step(0, 1'b1, 1'b1);
        compared++;
        if (acc_cnt[0] - start < npix) begin
            mismatched++;
            $display("FAIL timeout small: accepted %0d expected %0d", acc_cnt[0] - start, npix);
        end
        drain(0);
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic check_ends(input string name);
        int            first_v[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        int            last_v[9]  = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
        logic [WW-1:0] fw, lw;
        for (int k = 0; k < 9; k++) begin
            fw[k * PW +: PW] = PW'(first_v[k]);
            lw[k * PW +: PW] = PW'(last_v[k]);
        end
        compared++;
        if (got0.size() != 6 || got0[0] !== fw || got0[5] !== lw) begin
            mismatched++;
            $display("FAIL %s ends: got n=%0d first=%h last=%h expected 6 %h %h",
                     name, got0.size(), (got0.size() > 0) ? got0[0] : '0,
                     (got0.size() > 5) ? got0[5] : '0, fw, lw);
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b0; in_pixel[d] = '0;
            mf[d] = 0; reset_model(d);
        end
        repeat (2) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (out_valid[d] !== 1'b0 || out_win[d] !== '0 || frame_done[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
                mismatched++;
                $display("FAIL reset d%0d: got ov=%b win=%h fd=%b ir=%b expected 0 0 0 1",
                         d, out_valid[d], out_win[d], frame_done[d], in_ready[d]);
            end
`ifdef WIN_COORD_EN
            expect_int("reset coord", int'(out_row[d]) + int'(out_col[d]), 0);
`endif
            rst[d] = 1'b0; out_ready[d] = 1'b1;
        end
    endtask

    task automatic test_stream();
        set_ramp(0, 0); set_ramp(1, 0); reset_model(0);
        run_small(20);
        expect_int("stream windows", win_cnt[0], 6);
        expect_int("stream frame_done", done_cnt[0], 1);
        check_ends("stream");
    endtask

    task automatic test_backpressure();
        set_ramp(0, 0); set_ramp(1, 0); reset_model(0);
        stall_at[0] = 2; stall_left[0] = 4;
        run_small(20);
        expect_int("bp stall used", stall_left[0], 0);
        expect_int("bp windows", win_cnt[0], 6);
        check_ends("bp");
    endtask

    task automatic test_sign();
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < R0; r++)
                for (int c = 0; c < C0; c++)
                    img0[f][r][c] = ((r + c) % 3 == 0) ? 8'h80 : ((r + c) % 3 == 1) ? 8'h7f : PW'(r * 5 + c);
        reset_model(0);
        run_small(20);
        expect_int("sign windows", win_cnt[0], 6);
        expect_int("sign elem0", (got0.size() > 0) ? int'($signed(got0[0][PW-1:0])) : 0, -128);
        expect_int("sign elem1", (got0.size() > 0) ? int'($signed(got0[0][2*PW-1:PW])) : 0, 127);
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        set_ramp(mf[0] % 2, 0); set_ramp((mf[0] + 1) % 2, 64); reset_model(0);
        run_small(40);
        expect_int("b2b windows", win_cnt[0], 12);
        expect_int("b2b frame_done", done_cnt[0], 2);
        for (int i = 6; i < got0.size(); i++)
            for (int k = 0; k < 9; k++)
                if (got0[i][k * PW +: PW] < 8'd64) bad++;
        expect_int("b2b frame1 leak", bad, 0);
    endtask

    task automatic test_reset_mid();
        set_ramp(0, 0); set_ramp(1, 0); reset_model(0);
        for (int n = 0; n < 100 && win_cnt[0] < 2; n++) step(0, 1'b1, 1'b1);
        expect_int("mid windows before rst", win_cnt[0], 2);
        @(negedge clk);
        rst[0] = 1'b1; in_valid[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        #1;
        compared++;
        if (out_valid[0] !== 1'b0 || frame_done[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL mid reset: got ov=%b fd=%b ir=%b expected 0 0 1", out_valid[0], frame_done[0], in_ready[0]);
        end
        rst[0] = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        reset_model(0);
        run_small(20);
        expect_int("mid windows after rst", win_cnt[0], 6);
        check_ends("mid");
    endtask

    task automatic test_random_large();
        for (int r = 0; r < R1; r++)
            for (int c = 0; c < C1; c++)
                img1[r][c] = PW'($urandom);
        reset_model(1);
        for (int n = 0; n < 85000 && acc_cnt[1] < R1 * C1; n++)
            step(1, $urandom_range(15) != 0, $urandom_range(15) != 0);
        expect_int("large accepted", acc_cnt[1], R1 * C1);
        drain(1);
        expect_int("large windows", win_cnt[1], (R1 - 2) * (C1 - 2));
        expect_int("large frame_done", done_cnt[1], 1);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_sign();
        test_back_to_back();
        test_reset_mid();
        test_random_large();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
